oc15_scheduler: RTL and testbench
=================================

OC15_SCHEDULER -- requirements
Module: oc15_scheduler

Interface
REQ-001 Parameter SETTLE, default 3, is the number of cycles the shared 15-input ones counter is given to settle; legal range 1..15.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst_n  input  1  reset is synchronous and active-low; sampled on the rising clk edge.
REQ-004 req  input  4  request per requester i (0..3); level, held by the requester until its gnt bit pulses.
REQ-005 data  input  60  operand of requester i at bits [15*i+14 : 15*i]; valid whenever req[i]=1.
REQ-006 gnt  output  4  one-hot grant, one-cycle pulse.
REQ-007 oc_in  output  15  operand driven to the shared ones counter.
REQ-008 oc_cnt  input  4  count returned by the ones counter; bit 0 is the LSB.
REQ-009 res  output  4  captured ones count.
REQ-010 res_id  output  2  index of the requester that owns res.
REQ-011 res_valid  output  1  one-cycle pulse; res and res_id are valid.
REQ-012 busy  output  1  high in states LOAD and SETTLE.

Function
REQ-013 FSM states: IDLE, LOAD, SETTLE; all outputs registered.
REQ-014 IDLE with req==0: stay in IDLE; gnt=0; oc_in keeps its last value.
REQ-015 IDLE with req!=0: winner = first set bit searching ptr, ptr+1, ... mod 4.
REQ-016 On that edge: state->LOAD; gnt<=onehot(winner); oc_in<=data slice of winner; id register<=winner; ptr<=(winner+1) mod 4.
REQ-017 LOAD lasts exactly one cycle; gnt returns to 0 on the next edge.
REQ-018 LOAD->SETTLE edge: settle counter<=SETTLE-1.
REQ-019 SETTLE: the counter decrements each edge while nonzero.
REQ-020 SETTLE with counter==0: on the next edge res<=oc_cnt, res_id<=id register, res_valid<=1, state->IDLE.
REQ-021 res_valid is deasserted on every other edge; res and res_id hold until the next capture.
REQ-022 Latency: grant edge k gives res_valid high in the cycle after edge k+1+SETTLE (edge k+4 when SETTLE=3).
REQ-023 Throughput: one operation per SETTLE+2 cycles; a req seen in the IDLE cycle where res_valid=1 is granted on the following edge.
REQ-024 oc_in is stable from the grant edge until the next grant edge; the counter input never changes during SETTLE.
REQ-025 req changes while not in IDLE are ignored; the data slice is sampled only at the grant edge.
REQ-026 Only one gnt bit is ever set; gnt is never asserted outside the IDLE->LOAD transition.
REQ-027 oc_cnt is passed through unmodified; no arithmetic is done on it in this block.

Reset
REQ-028 rst_n=0 at an edge forces: state=IDLE, ptr=0, settle counter=0, gnt=0, oc_in=0, res=0, res_id=0, res_valid=0, busy=0.
REQ-029 rst_n asserted in LOAD or SETTLE aborts the operation; no res_valid is produced for it and no grant is reissued.
REQ-030 rst_n has priority over every other transition; the first grant after release follows REQ-015 with ptr=0.

Verification (bench uses a behavioural popcount model on oc_in, with SETTLE-1 cycles of delay, to drive oc_cnt)
REQ-031 rst_n=0 for 2 edges with random req and data -> every output is 0 and busy=0 on both edges.
REQ-032 SETTLE=3; req=0001, data[14:0]=15'h7FFF -> gnt=0001 for one cycle after edge k; res=4'hF, res_id=0, res_valid pulse after edge k+4.
REQ-033 req=1111 held; slices 15'h0000, 15'h5555, 15'h7FFF, 15'h0001 -> grant order 0,1,2,3,0; res sequence 0, 8, 15, 1, 0; res_valid spaced 5 cycles apart.
REQ-034 req=1010 held continuously -> grants alternate 1,3,1,3; requester 1 never receives two grants in a row.
REQ-035 Grant to requester 2, then rst_n=0 for one edge during SETTLE -> no res_valid; then req=0110 -> first grant goes to requester 1 (ptr reset to 0).
REQ-036 SETTLE=1; single req, data 15'h00FF -> res=8 with res_valid after edge k+2; busy high for exactly 2 cycles.

Source files
------------

// File: rtl/oc15_scheduler.sv
// oc15_scheduler: round-robin arbiter that lends one shared 15-input ones
// counter to four requesters. The winner's operand is driven to the counter,
// held for SETTLE cycles, and the returned count is captured with the
// winner's index.
//
// Ports
//   clk        rising-edge clock
//   rst_n      synchronous active-low reset
//   req[3:0]   level request per requester, held until its gnt bit pulses
//   data[59:0] operand of requester i at bits [15*i+14 : 15*i]
//   gnt[3:0]   one-hot grant pulse (one cycle)
//   oc_in      operand driven to the shared ones counter
//   oc_cnt     count returned by the ones counter
//   res        captured ones count
//   res_id     requester index that owns res
//   res_valid  one-cycle pulse qualifying res/res_id
//   busy       high while an operation is in LOAD or SETTLE
module oc15_scheduler #(
  parameter int unsigned SETTLE = 3
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [3:0]  req,
  input  logic [59:0] data,
  output logic [3:0]  gnt,
  output logic [14:0] oc_in,
  input  logic [3:0]  oc_cnt,
  output logic [3:0]  res,
  output logic [1:0]  res_id,
  output logic        res_valid,
  output logic        busy
);

  localparam int unsigned N_REQ = 4;
  localparam int unsigned OP_W  = 15;
  localparam int unsigned CNT_W = 4;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_LOAD   = 2'd1,
    ST_SETTLE = 2'd2
  } state_e;

  state_e            state_q;
  logic [1:0]        ptr_q;
  logic [1:0]        id_q;
  logic [CNT_W-1:0]  cnt_q;
  logic [3:0]        gnt_q;
  logic [OP_W-1:0]   oc_in_q;
  logic [3:0]        res_q;
  logic [1:0]        res_id_q;
  logic              res_valid_q;
  logic              busy_q;

  logic [OP_W-1:0]   slice [N_REQ];
  logic              win_found;
  logic [1:0]        win_idx;
  logic [1:0]        cand;
  logic [1:0]        ptr_d;
  logic [3:0]        gnt_d;
  logic [OP_W-1:0]   oc_in_d;

  // Split the flat operand bus into per-requester slices.
  for (genvar g = 0; g < N_REQ; g++) begin : g_slice
    assign slice[g] = data[OP_W*g +: OP_W];
  end

  // Rotating priority search starting at ptr_q; the first hit wins.
  always_comb begin
    win_found = 1'b0;
    win_idx   = ptr_q;
    cand      = ptr_q;
    for (int i = 0; i < N_REQ; i++) begin
      cand = ptr_q + 2'(i);
      if (!win_found && req[cand]) begin
        win_found = 1'b1;
        win_idx   = cand;
      end
    end
    ptr_d   = win_idx + 2'd1;
    gnt_d   = 4'b0001 << win_idx;
    oc_in_d = slice[win_idx];
  end

  // Controller: grant, hold operand for SETTLE cycles, capture the count.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      ptr_q       <= 2'd0;
      id_q        <= 2'd0;
      cnt_q       <= '0;
      gnt_q       <= 4'd0;
      oc_in_q     <= '0;
      res_q       <= 4'd0;
      res_id_q    <= 2'd0;
      res_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      res_valid_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (win_found) begin
            state_q <= ST_LOAD;
            gnt_q   <= gnt_d;
            oc_in_q <= oc_in_d;
            id_q    <= win_idx;
            ptr_q   <= ptr_d;
            busy_q  <= 1'b1;
          end
        end
        ST_LOAD: begin
          gnt_q   <= 4'd0;
          cnt_q   <= CNT_W'(SETTLE - 1);
          state_q <= ST_SETTLE;
        end
        ST_SETTLE: begin
          if (cnt_q != '0) begin
            cnt_q <= cnt_q - CNT_W'(1);
          end else begin
            // oc_cnt is taken as-is; the counter has had SETTLE cycles.
            res_q       <= oc_cnt;
            res_id_q    <= id_q;
            res_valid_q <= 1'b1;
            busy_q      <= 1'b0;
            state_q     <= ST_IDLE;
          end
        end
        default: begin
          state_q <= ST_IDLE;
          gnt_q   <= 4'd0;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign gnt       = gnt_q;
  assign oc_in     = oc_in_q;
  assign res       = res_q;
  assign res_id    = res_id_q;
  assign res_valid = res_valid_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_oc15_scheduler.sv
// Bench for oc15_scheduler: one instance with SETTLE=3 and one with SETTLE=1,
// each fed by a behavioural popcount model delayed by SETTLE-1 cycles.
module tb_oc15_scheduler;

  typedef struct packed {
    logic [1:0] id;
    logic [3:0] cnt;
  } exp_t;

  logic        clk;
  logic        rst_a, rst_b;
  logic [3:0]  req_a, req_b;
  logic [59:0] data_a, data_b;
  logic [3:0]  gnt_a, gnt_b;
  logic [14:0] oc_in_a, oc_in_b;
  logic [3:0]  oc_cnt_a, oc_cnt_b;
  logic [3:0]  res_a, res_b;
  logic [1:0]  res_id_a, res_id_b;
  logic        rv_a, rv_b;
  logic        busy_a, busy_b;

  int n_cmp = 0;
  int n_err = 0;
  int cyc_a = 0;
  int rv_cnt = 0;
  exp_t exp_q[$];
  int   rv_cyc[$];

  logic [3:0] pipe1 = 4'd0;
  logic [3:0] pipe2 = 4'd0;

  oc15_scheduler #(.SETTLE(3)) u_dut_a (
    .clk(clk), .rst_n(rst_a), .req(req_a), .data(data_a), .gnt(gnt_a),
    .oc_in(oc_in_a), .oc_cnt(oc_cnt_a), .res(res_a), .res_id(res_id_a),
    .res_valid(rv_a), .busy(busy_a)
  );

  oc15_scheduler #(.SETTLE(1)) u_dut_b (
    .clk(clk), .rst_n(rst_b), .req(req_b), .data(data_b), .gnt(gnt_b),
    .oc_in(oc_in_b), .oc_cnt(oc_cnt_b), .res(res_b), .res_id(res_id_b),
    .res_valid(rv_b), .busy(busy_b)
  );

  function automatic logic [3:0] pc15(input logic [14:0] v);
    return 4'($countones(v));
  endfunction

  // Ones-counter models: two register stages for SETTLE=3, none for SETTLE=1.
  always @(posedge clk) begin
    pipe1 <= pc15(oc_in_a);
    pipe2 <= pipe1;
    cyc_a <= cyc_a + 1;
  end
  assign oc_cnt_a = pipe2;
  assign oc_cnt_b = pc15(oc_in_b);

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Scoreboard for instance A: every res_valid pops one expected result.
  always @(negedge clk) begin
    if (rv_a) begin
      exp_t e;
      rv_cnt++;
      rv_cyc.push_back(cyc_a);
      if (exp_q.size() == 0) begin
        check_eq("unexpected_res_valid", 32'(rv_a), 32'd0);
      end else begin
        e = exp_q.pop_front();
        check_eq("res", 32'(res_a), 32'(e.cnt));
        check_eq("res_id", 32'(res_id_a), 32'(e.id));
      end
    end
    if (gnt_a != 4'd0) check_eq("gnt_onehot", 32'($onehot(gnt_a)), 32'd1);
  end

  task automatic wait_grant_a(output logic [3:0] g);
    g = 4'd0;
    for (int n = 0; n < 40 && g == 4'd0; n++) begin
      @(negedge clk);
      g = gnt_a;
    end
    if (g == 4'd0) check_eq("grant_timeout", 32'(g), 32'd1);
  endtask

  task automatic drain_a();
    for (int n = 0; n < 60 && exp_q.size() != 0; n++) @(negedge clk);
    check_eq("drain", 32'(exp_q.size()), 32'd0);
    @(negedge clk);
  endtask

  task automatic reset_a();
    rst_a = 1'b0;
    @(negedge clk);
    rst_a = 1'b1;
  endtask

  initial begin
    logic [3:0] g;
    logic [14:0] v;
    int k, lat, busy_n, nrv;
    int order [5];
    int alt [4];

    // Reset with random inputs.
    rst_a = 1'b0; rst_b = 1'b0;
    req_a = 4'($urandom); req_b = 4'($urandom);
    data_a = 60'({$urandom, $urandom}); data_b = 60'({$urandom, $urandom});
    repeat (2) begin
      @(negedge clk);
      check_eq("rst_gnt", 32'(gnt_a), 32'd0);
      check_eq("rst_oc_in", 32'(oc_in_a), 32'd0);
      check_eq("rst_res", 32'(res_a), 32'd0);
      check_eq("rst_res_id", 32'(res_id_a), 32'd0);
      check_eq("rst_res_valid", 32'(rv_a), 32'd0);
      check_eq("rst_busy", 32'(busy_a), 32'd0);
      check_eq("rst_b_all", 32'({gnt_b, oc_in_b, res_b, res_id_b, rv_b, busy_b}), 32'd0);
    end
    req_a = 4'd0; req_b = 4'd0;
    rst_a = 1'b1; rst_b = 1'b1;

    // Single request, all-ones operand, latency of four edges.
    data_a = '0;
    data_a[14:0] = 15'h7FFF;
    req_a = 4'b0001;
    exp_q.push_back('{id: 2'd0, cnt: 4'hF});
    wait_grant_a(g);
    check_eq("single_gnt", 32'(g), 32'h1);
    k = cyc_a;
    req_a = 4'd0;
    @(negedge clk);
    check_eq("gnt_one_cycle", 32'(gnt_a), 32'd0);
    lat = -1;
    for (int n = 2; n < 20 && lat < 0; n++) begin
      @(negedge clk);
      if (rv_a) lat = cyc_a - k;
    end
    check_eq("latency_s3", 32'(lat), 32'd4);
    drain_a();

    // All four requesting: round-robin order and back-to-back throughput.
    reset_a();
    data_a[14:0]  = 15'h0000;
    data_a[29:15] = 15'h5555;
    data_a[44:30] = 15'h7FFF;
    data_a[59:45] = 15'h0001;
    order = '{0, 1, 2, 3, 0};
    exp_q.push_back('{id: 2'd0, cnt: 4'd0});
    exp_q.push_back('{id: 2'd1, cnt: 4'd8});
    exp_q.push_back('{id: 2'd2, cnt: 4'd15});
    exp_q.push_back('{id: 2'd3, cnt: 4'd1});
    exp_q.push_back('{id: 2'd0, cnt: 4'd0});
    rv_cyc.delete();
    req_a = 4'b1111;
    for (int i = 0; i < 5; i++) begin
      wait_grant_a(g);
      check_eq("rr_gnt", 32'(g), 32'(4'b0001 << order[i]));
    end
    req_a = 4'd0;
    drain_a();
    check_eq("rr_rv_count", 32'(rv_cyc.size()), 32'd5);
    for (int i = 1; i < rv_cyc.size(); i++)
      check_eq("rr_spacing", 32'(rv_cyc[i] - rv_cyc[i-1]), 32'd5);

    // Requesters 1 and 3 only: strict alternation; data sampled at grant.
    alt = '{1, 3, 1, 3};
    data_a[29:15] = 15'($urandom);
    data_a[59:45] = 15'($urandom);
    req_a = 4'b1010;
    for (int i = 0; i < 4; i++) begin
      v = data_a[15*alt[i] +: 15];
      exp_q.push_back('{id: 2'(alt[i]), cnt: pc15(v)});
      wait_grant_a(g);
      check_eq("alt_gnt", 32'(g), 32'(4'b0001 << alt[i]));
      data_a[15*alt[i] +: 15] = 15'($urandom);
    end
    req_a = 4'd0;
    drain_a();

    // Reset during SETTLE aborts the operation and clears the pointer.
    reset_a();
    data_a[44:30] = 15'($urandom);
    req_a = 4'b0100;
    wait_grant_a(g);
    check_eq("abort_gnt", 32'(g), 32'h4);
    req_a = 4'd0;
    repeat (2) @(negedge clk);
    check_eq("abort_busy_pre", 32'(busy_a), 32'd1);
    rst_a = 1'b0;
    @(negedge clk);
    check_eq("abort_busy", 32'(busy_a), 32'd0);
    rst_a = 1'b1;
    nrv = rv_cnt;
    repeat (8) @(negedge clk);
    check_eq("abort_no_rv", 32'(rv_cnt), 32'(nrv));
    data_a[29:15] = 15'($urandom);
    v = data_a[29:15];
    exp_q.push_back('{id: 2'd1, cnt: pc15(v)});
    req_a = 4'b0110;
    wait_grant_a(g);
    check_eq("post_rst_gnt", 32'(g), 32'h2);
    req_a = 4'd0;
    drain_a();

    // SETTLE=1 instance: latency two edges, busy for two cycles.
    data_b = '0;
    data_b[14:0] = 15'h00FF;
    req_b = 4'b0001;
    g = 4'd0;
    for (int n = 0; n < 40 && g == 4'd0; n++) begin
      @(negedge clk);
      g = gnt_b;
    end
    check_eq("s1_gnt", 32'(g), 32'h1);
    req_b = 4'd0;
    busy_n = busy_b ? 1 : 0;
    lat = -1;
    for (int j = 1; j <= 10; j++) begin
      @(negedge clk);
      if (busy_b) busy_n++;
      if (rv_b && lat < 0) begin
        lat = j;
        check_eq("s1_res", 32'(res_b), 32'd8);
        check_eq("s1_res_id", 32'(res_id_b), 32'd0);
      end
    end
    check_eq("s1_latency", 32'(lat), 32'd2);
    check_eq("s1_busy_cycles", 32'(busy_n), 32'd2);

    check_eq("scoreboard_empty", 32'(exp_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
